// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, iterative 8x8 multiplier, CCR with shadow copy,
// and branch resolution. busy/flush_out steer the upstream pipeline latches.
module ex_stage #(
    parameter int W       = 8,
    parameter int MUL_CYC = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush_in,
    input  logic [1:0]   ra,
    input  logic [1:0]   rb,
    input  logic [W-1:0] R_ra,
    input  logic [W-1:0] R_rb,
    input  logic [W-1:0] imm,
    input  logic         imm_sel,
    input  logic [3:0]   alu_op,
    input  logic [4:0]   flag_ctl,
    input  logic         save_flags,
    input  logic [2:0]   bu,
    input  logic         exm_rw,
    input  logic [1:0]   exm_rd,
    input  logic [W-1:0] exm_data,
    input  logic         mwb_rw,
    input  logic [1:0]   mwb_rd,
    input  logic [W-1:0] mwb_data,
    output logic [W-1:0] alu_res,
    output logic [W-1:0] opb_fwd,
    output logic [3:0]   ccr,
    output logic         br_taken,
    output logic         flush_out,
    output logic         busy,
    output logic [1:0]   mul_state
);

    localparam int CW = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2*W-1:0]  prod;
    logic [2*W-1:0]  mcand;
    logic [W-1:0]    mplier;
    logic [3:0]      shadow;

    logic [W-1:0]    opa;
    logic [W-1:0]    opb;
    logic [W-1:0]    res;
    logic            fz, fn, fc, fv;
    logic [3:0]      flags_new;
    logic            br_cond;

    // Ex/M is the younger producer, so it wins over M/WB on a double match.
    always_comb begin
        opa = R_ra;
        if (exm_rw && exm_rd == ra)
            opa = exm_data;
        else if (mwb_rw && mwb_rd == ra)
            opa = mwb_data;

        opb_fwd = R_rb;
        if (exm_rw && exm_rd == rb)
            opb_fwd = exm_data;
        else if (mwb_rw && mwb_rd == rb)
            opb_fwd = mwb_data;
    end

    // Store data stays the forwarded register value; imm only replaces the ALU's B input.
    assign opb = imm_sel ? imm : opb_fwd;

    always_comb begin
        res = '0;
        fc  = ccr[2];
        fv  = ccr[3];
        case (alu_op)
            4'h0: res = opb;
            4'h1: begin
                {fc, res} = {1'b0, opa} + {1'b0, opb};
                fv = (opa[W-1] == opb[W-1]) && (res[W-1] != opa[W-1]);
            end
            4'h2: begin
                {fc, res} = {1'b0, opa} - {1'b0, opb};
                fv = (opa[W-1] != opb[W-1]) && (res[W-1] != opa[W-1]);
            end
            4'h3: res = opa & opb;
            4'h4: res = opa | opb;
            4'h5: begin
                res = {opb[W-2:0], ccr[2]};
                fc  = opb[W-1];
            end
            4'h6: begin
                res = {ccr[2], opb[W-1:1]};
                fc  = opb[0];
            end
            4'h7: begin
                res = opb;
                fc  = 1'b1;
            end
            4'h8: begin
                res = opb;
                fc  = 1'b0;
            end
            4'h9: res = ~opb;
            4'hA: begin
                {fc, res} = (W+1)'(0) - {1'b0, opb};
                fv = opb[W-1] && res[W-1];
            end
            4'hB: begin
                {fc, res} = {1'b0, opb} + (W+1)'(1);
                fv = !opb[W-1] && res[W-1];
            end
            4'hC: begin
                {fc, res} = {1'b0, opb} - (W+1)'(1);
                fv = opb[W-1] && !res[W-1];
            end
            4'hD: res = opa;
            4'hE: res = '0;
            4'hF: begin
                res = prod[W-1:0];
                fc  = |prod[2*W-1:W];
            end
            default: res = '0;
        endcase
        fz = (res == '0);
        fn = res[W-1];
        flags_new = (alu_op == 4'hE) ? ccr : {fv, fc, fn, fz};
    end

    assign alu_res   = res;
    assign busy      = (state == S_IDLE && alu_op == 4'hF && !flush_in) || (state == S_RUN);
    assign mul_state = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ccr    <= '0;
            shadow <= '0;
        end else if (!busy && !flush_in) begin
            if (save_flags)
                shadow <= ccr;
            if (flag_ctl[4])
                ccr <= shadow;
            else
                ccr <= (flags_new & flag_ctl[3:0]) | (ccr & ~flag_ctl[3:0]);
        end
    end

    // DONE always returns to IDLE so the MUL still held on the inputs cannot restart.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (alu_op == 4'hF && !flush_in) begin
                        mcand  <= {{W{1'b0}}, opa};
                        mplier <= opb;
                        prod   <= '0;
                        cnt    <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (flush_in) begin
                        state <= S_IDLE;
                    end else begin
                        if (mplier[0])
                            prod <= prod + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                        if (cnt == CW'(MUL_CYC - 1))
                            state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        case (bu)
            3'd1:    br_cond = ccr[0];
            3'd2:    br_cond = ccr[1];
            3'd3:    br_cond = ccr[2];
            3'd4:    br_cond = ccr[3];
            3'd5,
            3'd6,
            3'd7:    br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
    end

    assign br_taken  = br_cond && !busy && !flush_in;
    assign flush_out = br_taken;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: hand-computed vector table, directed multi-cycle sequences,
// and random operations checked against an arithmetic reference model.
module tb_ex_stage;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         flush_in;
    logic [1:0]   ra, rb;
    logic [W-1:0] R_ra, R_rb, imm;
    logic         imm_sel;
    logic [3:0]   alu_op;
    logic [4:0]   flag_ctl;
    logic         save_flags;
    logic [2:0]   bu;
    logic         exm_rw;
    logic [1:0]   exm_rd;
    logic [W-1:0] exm_data;
    logic         mwb_rw;
    logic [1:0]   mwb_rd;
    logic [W-1:0] mwb_data;
    logic [W-1:0] alu_res, opb_fwd;
    logic [3:0]   ccr;
    logic         br_taken, flush_out, busy;
    logic [1:0]   mul_state;

    ex_stage #(.W(W), .MUL_CYC(8)) dut (
        .clk(clk), .reset(reset), .flush_in(flush_in),
        .ra(ra), .rb(rb), .R_ra(R_ra), .R_rb(R_rb), .imm(imm), .imm_sel(imm_sel),
        .alu_op(alu_op), .flag_ctl(flag_ctl), .save_flags(save_flags), .bu(bu),
        .exm_rw(exm_rw), .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_rw(mwb_rw), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .alu_res(alu_res), .opb_fwd(opb_fwd), .ccr(ccr), .br_taken(br_taken),
        .flush_out(flush_out), .busy(busy), .mul_state(mul_state)
    );

    typedef struct {
        logic [1:0] ra, rb;
        logic [7:0] r_ra, r_rb, imm;
        logic       imm_sel;
        logic [3:0] alu_op;
        logic [4:0] flag_ctl;
        logic       save_flags;
        logic [2:0] bu;
        logic       flush;
        logic       exm_rw;
        logic [1:0] exm_rd;
        logic [7:0] exm_data;
        logic       mwb_rw;
        logic [1:0] mwb_rd;
        logic [7:0] mwb_data;
    } in_t;

    typedef struct {
        in_t        in;
        logic [7:0] exp_res, exp_opb;
        logic [3:0] exp_ccr;
        logic       exp_br;
    } vec_t;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] m_ccr, m_shadow;
    logic [W-1:0] exp_q[$];
    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input in_t v);
        ra = v.ra; rb = v.rb; R_ra = v.r_ra; R_rb = v.r_rb; imm = v.imm;
        imm_sel = v.imm_sel; alu_op = v.alu_op; flag_ctl = v.flag_ctl;
        save_flags = v.save_flags; bu = v.bu; flush_in = v.flush;
        exm_rw = v.exm_rw; exm_rd = v.exm_rd; exm_data = v.exm_data;
        mwb_rw = v.mwb_rw; mwb_rd = v.mwb_rd; mwb_data = v.mwb_data;
    endtask

    function automatic in_t mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic [4:0] fc, input logic [2:0] bt);
        in_t v;
        v.ra = 2'd0; v.rb = 2'd1; v.r_ra = a; v.r_rb = b; v.imm = 8'h00; v.imm_sel = 1'b0;
        v.alu_op = op; v.flag_ctl = fc; v.save_flags = 1'b0; v.bu = bt; v.flush = 1'b0;
        v.exm_rw = 1'b0; v.exm_rd = 2'd0; v.exm_data = 8'h00;
        v.mwb_rw = 1'b0; v.mwb_rd = 2'd0; v.mwb_data = 8'h00;
        return v;
    endfunction

    task automatic add_vec(input in_t v, input logic [7:0] r, input logic [7:0] ob,
                           input logic [3:0] cc, input logic br);
        vec_t t;
        t.in = v; t.exp_res = r; t.exp_opb = ob; t.exp_ccr = cc; t.exp_br = br;
        tbl.push_back(t);
    endtask

    // reference model
    function automatic logic [7:0] fwd_m(input logic [1:0] idx, input logic [7:0] rf, input in_t v);
        if (v.exm_rw && v.exm_rd == idx) return v.exm_data;
        if (v.mwb_rw && v.mwb_rd == idx) return v.mwb_data;
        return rf;
    endfunction

    function automatic void ref_alu(input logic [3:0] op, input int a, input int b,
                                    input logic [3:0] cc, output logic [7:0] res,
                                    output logic [3:0] fl);
        int r, sa, sb;
        logic c, v, z, n;
        c = cc[2]; v = cc[3];
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        case (op)
            4'h0: r = b;
            4'h1: begin r = a + b; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            4'h2: begin r = a - b; c = (r < 0);   v = (sa - sb > 127) || (sa - sb < -128); end
            4'h3: r = a & b;
            4'h4: r = a | b;
            4'h5: begin r = b * 2 + (cc[2] ? 1 : 0); c = (b >= 128); end
            4'h6: begin r = b / 2 + (cc[2] ? 128 : 0); c = ((b % 2) == 1); end
            4'h7: begin r = b; c = 1'b1; end
            4'h8: begin r = b; c = 1'b0; end
            4'h9: r = 255 - b;
            4'hA: begin r = -b; c = (b != 0); v = (-sb > 127); end
            4'hB: begin r = b + 1; c = (r > 255); v = (sb + 1 > 127); end
            4'hC: begin r = b - 1; c = (r < 0);   v = (sb - 1 < -128); end
            4'hD: r = a;
            4'hE: r = 0;
            default: begin r = a * b; c = (r > 255); end
        endcase
        res = 8'(r & 255);
        z = (res == 8'h00);
        n = (res >= 8'h80);
        fl = (op == 4'hE) ? cc : {v, c, n, z};
    endfunction

    function automatic logic br_m(input logic [2:0] bt, input logic [3:0] cc);
        case (bt)
            3'd0: return 1'b0;
            3'd1: return cc[0];
            3'd2: return cc[1];
            3'd3: return cc[2];
            3'd4: return cc[3];
            default: return 1'b1;
        endcase
    endfunction

    // scoreboard-checked single operation, including the multi-cycle MUL path
    task automatic run_op(input in_t v);
        logic [7:0] a, bs, b, r;
        logic [3:0] fl, nccr;
        logic       br_e;
        int         n;
        a  = fwd_m(v.ra, v.r_ra, v);
        bs = fwd_m(v.rb, v.r_rb, v);
        b  = v.imm_sel ? v.imm : bs;
        @(negedge clk);
        drive(v);
        #1;
        ref_alu(v.alu_op, int'(a), int'(b), m_ccr, r, fl);
        if (v.alu_op == 4'hF && !v.flush) begin
            check("mul_issue_busy", int'(busy), 1);
            n = 0;
            while (busy === 1'b1 && n < 30) begin
                n++;
                @(posedge clk);
                #1;
            end
            check("mul_stall_cycles", n, 9);
            check("mul_done_state", int'(mul_state), 2);
            exp_q.push_back(r);
            check("mul_res", int'(alu_res), int'(exp_q.pop_front()));
            check("mul_done_br", int'(br_taken), int'(br_m(v.bu, m_ccr)));
        end else begin
            if (v.alu_op != 4'hF) begin
                exp_q.push_back(r);
                check("alu_res", int'(alu_res), int'(exp_q.pop_front()));
            end
            check("opb_fwd", int'(opb_fwd), int'(bs));
            check("busy_low", int'(busy), 0);
        end
        br_e = v.flush ? 1'b0 : br_m(v.bu, m_ccr);
        if (!(v.alu_op == 4'hF && !v.flush))
            check("br_taken", int'(br_taken), int'(br_e));
        check("flush_out", int'(flush_out), int'(br_e));
        @(posedge clk);
        #1;
        if (!v.flush) begin
            nccr = v.flag_ctl[4] ? m_shadow : ((fl & v.flag_ctl[3:0]) | (m_ccr & ~v.flag_ctl[3:0]));
            if (v.save_flags) m_shadow = m_ccr;
            m_ccr = nccr;
        end
        check("ccr", int'(ccr), int'(m_ccr));
        check("state_idle", int'(mul_state), 0);
    endtask

    initial begin
        in_t  v;
        logic [3:0] ccr_before;

        drive(mk(4'h0, 8'h00, 8'h00, 5'h00, 3'd0));
        reset = 1'b0;
        m_ccr = 4'h0;
        m_shadow = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ccr", int'(ccr), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_state", int'(mul_state), 0);
        @(negedge clk);
        reset = 1'b1;

        // hand-computed vectors, applied in order from ccr=0
        add_vec(mk(4'h1, 8'h7F, 8'h01, 5'h0F, 3'd7), 8'h80, 8'h01, 4'hA, 1'b1);
        v = mk(4'hD, 8'h00, 8'h00, 5'h00, 3'd4);
        v.ra = 2'd1; v.exm_rw = 1'b1; v.exm_rd = 2'd1; v.exm_data = 8'h11;
        v.mwb_rw = 1'b1; v.mwb_rd = 2'd1; v.mwb_data = 8'h22;
        add_vec(v, 8'h11, 8'h11, 4'hA, 1'b1);
        v = mk(4'h0, 8'h00, 8'h55, 5'h03, 3'd0);
        v.rb = 2'd2; v.mwb_rw = 1'b1; v.mwb_rd = 2'd2; v.mwb_data = 8'h33;
        v.exm_rw = 1'b1; v.exm_rd = 2'd3; v.exm_data = 8'h44;
        add_vec(v, 8'h33, 8'h33, 4'h8, 1'b0);
        add_vec(mk(4'h2, 8'h00, 8'h01, 5'h0F, 3'd0), 8'hFF, 8'h01, 4'h6, 1'b0);
        add_vec(mk(4'h5, 8'h00, 8'h80, 5'h0F, 3'd0), 8'h01, 8'h80, 4'h4, 1'b0);
        v = mk(4'h0, 8'h00, 8'h12, 5'h01, 3'd0);
        v.imm = 8'h00; v.imm_sel = 1'b1;
        add_vec(v, 8'h00, 8'h12, 4'h5, 1'b0);
        add_vec(mk(4'hA, 8'h00, 8'h80, 5'h0F, 3'd0), 8'h80, 8'h80, 4'hE, 1'b0);
        add_vec(mk(4'hC, 8'h00, 8'h00, 5'h0F, 3'd0), 8'hFF, 8'h00, 4'h6, 1'b0);
        add_vec(mk(4'hB, 8'h00, 8'hFF, 5'h0F, 3'd0), 8'h00, 8'hFF, 4'h5, 1'b0);
        add_vec(mk(4'h6, 8'h00, 8'h02, 5'h0F, 3'd0), 8'h81, 8'h02, 4'h2, 1'b0);
        add_vec(mk(4'h7, 8'h00, 8'h5A, 5'h04, 3'd0), 8'h5A, 8'h5A, 4'h6, 1'b0);
        add_vec(mk(4'h3, 8'hF0, 8'h0F, 5'h01, 3'd0), 8'h00, 8'h0F, 4'h7, 1'b0);
        add_vec(mk(4'h4, 8'hF0, 8'h0F, 5'h03, 3'd1), 8'hFF, 8'h0F, 4'h6, 1'b1);
        add_vec(mk(4'h9, 8'h00, 8'h0F, 5'h03, 3'd1), 8'hF0, 8'h0F, 4'h6, 1'b0);
        add_vec(mk(4'h8, 8'h00, 8'h00, 5'h04, 3'd3), 8'h00, 8'h00, 4'h2, 1'b1);
        v = mk(4'h1, 8'h01, 8'h01, 5'h0F, 3'd5);
        v.flush = 1'b1;
        add_vec(v, 8'h02, 8'h01, 4'h2, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].in);
            #1;
            check($sformatf("tbl%0d_res", i), int'(alu_res), int'(tbl[i].exp_res));
            check($sformatf("tbl%0d_opb", i), int'(opb_fwd), int'(tbl[i].exp_opb));
            check($sformatf("tbl%0d_br", i), int'(br_taken), int'(tbl[i].exp_br));
            check($sformatf("tbl%0d_flush_out", i), int'(flush_out), int'(tbl[i].exp_br));
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_ccr", i), int'(ccr), int'(tbl[i].exp_ccr));
        end
        m_ccr = 4'h2;

        // MUL 0x10*0x10: nine stall cycles, zero low byte with carry, next op straight after
        run_op(mk(4'hF, 8'h10, 8'h10, 5'h0F, 3'd0));
        check("mul_zc_flags", int'({ccr[2], ccr[0]}), 3);
        run_op(mk(4'h1, 8'h03, 8'h04, 5'h00, 3'd0));

        // flush during RUN cycle 3
        ccr_before = m_ccr;
        @(negedge clk);
        drive(mk(4'hF, 8'h03, 8'h05, 5'h0F, 3'd0));
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush_in = 1'b1;
        #1;
        check("flush_run_busy", int'(busy), 1);
        @(posedge clk);
        #1;
        check("flush_busy_next", int'(busy), 0);
        check("flush_state", int'(mul_state), 0);
        @(negedge clk);
        drive(mk(4'hE, 8'h00, 8'h00, 5'h00, 3'd0));
        @(posedge clk);
        #1;
        check("flush_ccr_kept", int'(ccr), int'(ccr_before));

        // reset while the multiplier is running
        @(negedge clk);
        drive(mk(4'hF, 8'h03, 8'h05, 5'h0F, 3'd0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(mk(4'hE, 8'h00, 8'h00, 5'h00, 3'd0));
        @(posedge clk);
        #1;
        check("midmul_reset_state", int'(mul_state), 0);
        check("midmul_reset_busy", int'(busy), 0);
        check("midmul_reset_ccr", int'(ccr), 0);
        reset = 1'b1;
        m_ccr = 4'h0;
        m_shadow = 4'h0;

        // shadow save / restore, then branch on restored Z
        run_op(mk(4'hB, 8'h00, 8'hFF, 5'h0F, 3'd0));
        check("pre_save_ccr", int'(ccr), 5);
        v = mk(4'hE, 8'h00, 8'h00, 5'h00, 3'd0);
        v.save_flags = 1'b1;
        run_op(v);
        run_op(mk(4'h1, 8'h01, 8'h01, 5'h0F, 3'd0));
        check("cleared_ccr", int'(ccr), 0);
        run_op(mk(4'h1, 8'h01, 8'h01, 5'h1F, 3'd0));
        check("restored_ccr", int'(ccr), 5);
        @(negedge clk);
        drive(mk(4'hE, 8'h00, 8'h00, 5'h00, 3'd1));
        #1;
        check("restore_br_taken", int'(br_taken), 1);
        check("restore_flush_out", int'(flush_out), 1);
        @(posedge clk);

        // random operations against the reference model
        for (int i = 0; i < 150; i++) begin
            v.ra = 2'($urandom_range(0, 3));
            v.rb = 2'($urandom_range(0, 3));
            v.r_ra = 8'($urandom);
            v.r_rb = 8'($urandom);
            v.imm = 8'($urandom);
            v.imm_sel = ($urandom_range(0, 3) == 0);
            v.alu_op = 4'($urandom_range(0, 15));
            v.flag_ctl = {($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15))};
            v.save_flags = ($urandom_range(0, 5) == 0);
            v.bu = 3'($urandom_range(0, 7));
            v.flush = ($urandom_range(0, 9) == 0);
            v.exm_rw = 1'($urandom_range(0, 1));
            v.exm_rd = 2'($urandom_range(0, 3));
            v.exm_data = 8'($urandom);
            v.mwb_rw = 1'($urandom_range(0, 1));
            v.mwb_rd = 2'($urandom_range(0, 3));
            v.mwb_data = 8'($urandom);
            run_op(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
